// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Control sequencer for a multicycle RV32I-style datapath. Walks each
// instruction through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK and
// parks in TRAP on an unsupported opcode until reset.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-low reset
//   opcode/funct3/funct7_5: fields of the latched instruction register
//   alu_zero/lt/ltu       : ALU compare flags (used by branches in EXECUTE)
//   mem_req/mem_we/mem_ready : memory handshake
//   pc_write, ir_write, reg_write, adr_src : datapath strobes and address mux
//   alu_op, alu_src_a, alu_src_b, result_src : datapath mux/ALU controls
//   illegal               : sticky illegal-instruction flag (TRAP)
//   state                 : current state encoding
//
// state     | meaning
// FETCH   0 | read instruction, PC <= PC+4 on mem_ready
// DECODE  1 | one cycle, ALU forms PC-relative target, opcode screened
// EXECUTE 2 | ALU operation / branch resolve / jump link
// MEMORY  3 | data access, held until mem_ready
// WRITEBACK 4 | register file write
// TRAP    7 | illegal instruction, exit only by reset
module multicycle_control_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd7
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    state_t state_q, state_d;

    logic is_r, is_i, is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st;
    logic legal_op, br_taken, br_bad;

    assign is_r     = (opcode == 7'b0110011);
    assign is_i     = (opcode == 7'b0010011);
    assign is_lui   = (opcode == 7'b0110111);
    assign is_auipc = (opcode == 7'b0010111);
    assign is_jal   = (opcode == 7'b1101111);
    assign is_jalr  = (opcode == 7'b1100111);
    assign is_br    = (opcode == 7'b1100011);
    assign is_ld    = (opcode == 7'b0000011);
    assign is_st    = (opcode == 7'b0100011);
    assign legal_op = is_r | is_i | is_lui | is_auipc | is_jal | is_jalr
                    | is_br | is_ld | is_st;

    assign br_bad = (funct3 == 3'b010) || (funct3 == 3'b011);

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = ~alu_zero;
            3'b100:  br_taken = alu_lt;
            3'b101:  br_taken = ~alu_lt;
            3'b110:  br_taken = alu_ltu;
            3'b111:  br_taken = ~alu_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        alu_op     = ALU_ADD;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        result_src = 2'd0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = 2'd0;
                alu_src_b = 2'd2;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                state_d   = legal_op ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                if (is_r) begin
                    alu_src_b = 2'd0;
                    alu_op    = {funct7_5, funct3};
                    state_d   = S_WRITEBACK;
                end else if (is_i) begin
                    // only SRLI/SRAI carry an operation bit in funct7
                    alu_op  = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
                    state_d = S_WRITEBACK;
                end else if (is_lui) begin
                    state_d = S_WRITEBACK;
                end else if (is_auipc) begin
                    alu_src_a = 2'd1;
                    state_d   = S_WRITEBACK;
                end else if (is_ld || is_st) begin
                    state_d = S_MEMORY;
                end else if (is_br) begin
                    alu_src_b = 2'd0;
                    alu_op    = ALU_SUB;
                    if (br_bad) begin
                        state_d = S_TRAP;
                    end else begin
                        // target already sits in ALU out from DECODE
                        pc_write = br_taken;
                        state_d  = S_FETCH;
                    end
                end else if (is_jal || is_jalr) begin
                    // link value is old PC + 4, written straight from the ALU
                    alu_src_a  = 2'd1;
                    alu_src_b  = 2'd2;
                    reg_write  = 1'b1;
                    result_src = 2'd2;
                    pc_write   = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEMORY: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_we  = is_st;
                if (mem_ready) state_d = is_ld ? S_WRITEBACK : S_FETCH;
            end
            S_WRITEBACK: begin
                reg_write  = 1'b1;
                result_src = is_ld ? 2'd1 : 2'd0;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // reset kills every strobe in the cycle it is sampled, mid-handshake included
        if (!reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign state   = state_q;
    assign illegal = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, pc_write, ir_write, reg_write, adr_src, illegal;
    logic [3:0] alu_op;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] state;

    multicycle_control_fsm dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .adr_src(adr_src), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .illegal(illegal),
        .state(state)
    );

    always #5 clock = ~clock;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_BR = 7'b1100011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;

    // one expected clock cycle: inputs to drive plus the outputs required
    typedef struct {
        logic [2:0] st;
        logic       rstn, rdy;
        logic       pcw, irw, rw, mreq, mwe, adr, ill;
        logic       chk_rsrc, chk_aop;
        logic [1:0] rsrc;
        logic [3:0] aop;
    } cyc_t;

    cyc_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic legal(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST};
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic z, lt, ltu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    // mem_ready is random wherever the spec says it must be ignored
    function automatic cyc_t base(input logic [2:0] st);
        cyc_t e;
        e.st = st; e.rstn = 1'b1; e.rdy = 1'($urandom % 2);
        e.pcw = 0; e.irw = 0; e.rw = 0; e.mreq = 0; e.mwe = 0; e.adr = 0; e.ill = 0;
        e.chk_rsrc = 0; e.chk_aop = 0; e.rsrc = 2'd0; e.aop = 4'd0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic add_trap(input int n);
        cyc_t e;
        for (int i = 0; i < n; i++) begin
            e = base(3'd7); e.ill = 1; q.push_back(e);
        end
        e = base(3'd7); e.ill = 1; e.rstn = 0; q.push_back(e);
    endtask

    // expected cycle trace of one instruction, from the per-class sequencing rules
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, lt, ltu, input int fw, mw, abort_at, tlen);
        cyc_t e;
        for (int i = 0; i <= fw; i++) begin
            e = base(3'd0); e.rdy = (i == fw); e.mreq = 1;
            e.pcw = (i == fw); e.irw = (i == fw); e.chk_aop = 1;
            q.push_back(e);
        end
        e = base(3'd1); e.chk_aop = 1; q.push_back(e);
        if (!legal(op)) begin add_trap(tlen); return; end

        e = base(3'd2); e.chk_aop = 1;
        if (op == OP_R)       e.aop = {f7, f3};
        else if (op == OP_I)  e.aop = {(f3 == 3'b101) ? f7 : 1'b0, f3};
        else if (op == OP_BR) e.aop = 4'b1000;
        if (op == OP_BR) begin
            if (f3 == 3'b010 || f3 == 3'b011) begin
                q.push_back(e); add_trap(tlen); return;
            end
            e.pcw = taken(f3, z, lt, ltu); q.push_back(e); return;
        end
        if (op == OP_JAL || op == OP_JALR) begin
            e.pcw = 1; e.rw = 1; e.chk_rsrc = 1; e.rsrc = 2'd2; q.push_back(e); return;
        end
        q.push_back(e);

        if (op == OP_LD || op == OP_ST) begin
            for (int i = 0; i <= mw; i++) begin
                e = base(3'd3); e.rdy = (i == mw); e.mreq = 1; e.mwe = (op == OP_ST); e.adr = 1;
                if (i == abort_at) begin
                    e.rstn = 0; e.mreq = 0; e.mwe = 0; q.push_back(e); return;
                end
                q.push_back(e);
            end
            if (op == OP_ST) return;
        end
        e = base(3'd4); e.rw = 1; e.chk_rsrc = 1; e.rsrc = (op == OP_LD) ? 2'd1 : 2'd0;
        q.push_back(e);
    endtask

    task automatic play(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic z, lt, ltu);
        cyc_t e;
        bit first = 1;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clock);
            if (first) begin
                opcode = op; funct3 = f3; funct7_5 = f7;
                alu_zero = z; alu_lt = lt; alu_ltu = ltu;
                first = 0;
            end
            reset = e.rstn; mem_ready = e.rdy;
            #1;
            chk("state", 8'(state), 8'(e.st));
            chk("strobes", 8'({pc_write, ir_write, reg_write, mem_req, mem_we}),
                8'({e.pcw, e.irw, e.rw, e.mreq, e.mwe}));
            chk("illegal", 8'(illegal), 8'(e.ill));
            if (e.mreq) chk("adr_src", 8'(adr_src), 8'(e.adr));
            if (e.chk_rsrc) chk("result_src", 8'(result_src), 8'(e.rsrc));
            if (e.chk_aop) chk("alu_op", 8'(alu_op), 8'(e.aop));
        end
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, lt, ltu, input int fw, mw, abort_at, tlen);
        build(op, f3, f7, z, lt, ltu, fw, mw, abort_at, tlen);
        play(op, f3, f7, z, lt, ltu);
    endtask

    logic [6:0] ops[9] = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST};

    initial begin
        cyc_t e;
        logic [6:0] op;
        int ab;

        // reset held low: FETCH, no strobes, no illegal
        for (int i = 0; i < 2; i++) begin
            e = base(3'd0); e.rstn = 0; q.push_back(e);
        end
        play(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ADD x3,x1,x2
        run(OP_R, 3'b000, 1'b0, 0, 0, 0, 0, 0, -1, 0);
        // LW with three wait cycles in MEMORY
        run(OP_LD, 3'b010, 1'b0, 0, 0, 0, 0, 3, -1, 0);
        // BEQ taken and not taken
        run(OP_BR, 3'b000, 1'b0, 1, 0, 0, 0, 0, -1, 0);
        run(OP_BR, 3'b000, 1'b0, 0, 1, 1, 0, 0, -1, 0);
        // SUB and SRAI operation bits
        run(OP_R, 3'b000, 1'b1, 0, 0, 0, 1, 0, -1, 0);
        run(OP_I, 3'b101, 1'b1, 0, 0, 0, 0, 0, -1, 0);
        run(OP_I, 3'b000, 1'b1, 0, 0, 0, 0, 0, -1, 0);
        // illegal opcode: TRAP for 10 cycles, then reset
        run(7'b1111111, 3'b000, 1'b0, 0, 0, 0, 0, 0, -1, 10);
        // SW with reset mid-MEMORY
        run(OP_ST, 3'b010, 1'b0, 0, 0, 0, 0, 3, 2, 0);
        // branch with reserved funct3
        run(OP_BR, 3'b010, 1'b0, 0, 0, 0, 0, 0, -1, 3);
        run(OP_JAL, 3'b000, 1'b0, 0, 0, 0, 2, 0, -1, 0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom % 12 == 0) begin
                do op = 7'($urandom); while (legal(op));
            end else begin
                op = ops[$urandom % 9];
            end
            ab = -1;
            if ((op == OP_LD || op == OP_ST) && ($urandom % 8 == 0)) ab = int'($urandom % 4);
            run(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom % 4), int'($urandom % 4), ab, int'($urandom_range(1, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
